// File: rtl/mintr_cntrl.sv
// Machine-mode interrupt controller: registers software, timer and external lines,
// tracks per-line pending state, and hands one fixed-priority interrupt to the trap logic.
module mintr_cntrl #(
  parameter int                 XLEN      = 32,
  parameter int                 NUM_EXT   = 8,
  parameter logic [NUM_EXT-1:0] EDGE_MASK = '0,
  parameter int                 EXT_ID_W  = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                msip,
  input  logic                mtip,
  input  logic [NUM_EXT-1:0]  ext_irq,
  input  logic                mstatus_mie,
  input  logic                mie_msie,
  input  logic                mie_mtie,
  input  logic                mie_meie,
  input  logic [NUM_EXT-1:0]  ext_en,
  input  logic                intr_ack,
  input  logic                intr_complete,
  output logic                intr_req,
  output logic [XLEN-1:0]     intr_cause,
  output logic [EXT_ID_W-1:0] ext_id,
  output logic [XLEN-1:0]     mip
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t              state_q, state_d;
  logic [NUM_EXT-1:0]  ext_q, ext_d;
  logic [NUM_EXT-1:0]  ext_dly_q, ext_dly_d;
  logic [NUM_EXT-1:0]  edge_pend_q, edge_pend_d;
  logic [NUM_EXT-1:0]  in_service_q, in_service_d;
  logic                msip_q, msip_d;
  logic                mtip_q, mtip_d;
  logic                intr_req_q, intr_req_d;
  logic [XLEN-1:0]     cause_q, cause_d;
  logic [EXT_ID_W-1:0] ext_id_q, ext_id_d;

  logic [NUM_EXT-1:0]  ext_rise;
  logic [NUM_EXT-1:0]  ext_pend;
  logic [NUM_EXT-1:0]  ext_cand;
  logic [NUM_EXT-1:0]  id_onehot;
  logic [NUM_EXT-1:0]  ack_clr;
  logic [EXT_ID_W-1:0] sel_id;
  logic                mei, msi, mti;
  logic [3:0]          sel_code;

  // A fresh rising edge counts as pending in the same cycle so edge lines see the same latency as level lines.
  always_comb begin
    ext_d     = ext_irq;
    ext_dly_d = ext_q;
    msip_d    = msip;
    mtip_d    = mtip;
    ext_rise  = ext_q & ~ext_dly_q;
    ext_pend  = (ext_q & ~EDGE_MASK) | ((edge_pend_q | ext_rise) & EDGE_MASK);
    ext_cand  = ext_pend & ext_en & ~in_service_q;
    mei       = mstatus_mie & mie_meie & (|ext_cand);
    msi       = mstatus_mie & mie_msie & msip_q;
    mti       = mstatus_mie & mie_mtie & mtip_q;
    sel_id    = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (ext_cand[i]) sel_id = i[EXT_ID_W-1:0];
    end
    sel_code = mei ? 4'd11 : (msi ? 4'd3 : 4'd7);
    id_onehot = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (ext_id_q == i[EXT_ID_W-1:0]) id_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    intr_req_d   = intr_req_q;
    cause_d      = cause_q;
    ext_id_d     = ext_id_q;
    in_service_d = in_service_q;
    ack_clr      = '0;
    case (state_q)
      IDLE: begin
        if (mei | msi | mti) begin
          state_d    = REQ;
          intr_req_d = 1'b1;
          cause_d    = {1'b1, {(XLEN-5){1'b0}}, sel_code};
          ext_id_d   = sel_id;
        end
      end
      REQ: begin
        if (intr_ack) begin
          state_d    = SERVICE;
          intr_req_d = 1'b0;
          if (cause_q[3:0] == 4'd11) begin
            in_service_d = in_service_q | id_onehot;
            ack_clr      = id_onehot;
          end
        end
      end
      SERVICE: begin
        // A coincident ack takes precedence, so complete is dropped in that cycle.
        if (intr_complete && !intr_ack) begin
          state_d      = IDLE;
          in_service_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        intr_req_d = 1'b0;
      end
    endcase
    edge_pend_d = EDGE_MASK & (ext_rise | (edge_pend_q & ~ack_clr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ext_q        <= '0;
      ext_dly_q    <= '0;
      edge_pend_q  <= '0;
      in_service_q <= '0;
      msip_q       <= 1'b0;
      mtip_q       <= 1'b0;
      intr_req_q   <= 1'b0;
      cause_q      <= '0;
      ext_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      ext_q        <= ext_d;
      ext_dly_q    <= ext_dly_d;
      edge_pend_q  <= edge_pend_d;
      in_service_q <= in_service_d;
      msip_q       <= msip_d;
      mtip_q       <= mtip_d;
      intr_req_q   <= intr_req_d;
      cause_q      <= cause_d;
      ext_id_q     <= ext_id_d;
    end
  end

  // mip shows live pending state regardless of the handshake or the global enable.
  always_comb begin
    mip     = '0;
    mip[3]  = msip_q;
    mip[7]  = mtip_q;
    mip[11] = |(ext_pend & ext_en);
  end

  assign intr_req   = intr_req_q;
  assign intr_cause = cause_q;
  assign ext_id     = ext_id_q;

endmodule

// File: tb/tb_mintr_cntrl.sv
// Randomised and directed bench for mintr_cntrl; a behavioural model predicts each request
// and a monitor pops the prediction when the DUT raises intr_req.
module tb_mintr_cntrl;

  localparam int               XLEN      = 32;
  localparam int               NUM_EXT   = 8;
  localparam int               EXT_ID_W  = 3;
  localparam logic [NUM_EXT-1:0] EDGE_MASK = 8'b0000_0100;
  localparam logic [31:0]      CAUSE_MEI = 32'h8000_000B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic msip = 1'b1, mtip = 1'b1;
  logic [NUM_EXT-1:0] ext_irq = '1;
  logic mstatus_mie = 1'b1, mie_msie = 1'b1, mie_mtie = 1'b1, mie_meie = 1'b1;
  logic [NUM_EXT-1:0] ext_en = '1;
  logic intr_ack = 1'b1, intr_complete = 1'b1;
  logic intr_req;
  logic [XLEN-1:0] intr_cause;
  logic [EXT_ID_W-1:0] ext_id;
  logic [XLEN-1:0] mip;

  mintr_cntrl #(.XLEN(XLEN), .NUM_EXT(NUM_EXT), .EDGE_MASK(EDGE_MASK)) dut (
    .clk(clk), .rst(rst), .msip(msip), .mtip(mtip), .ext_irq(ext_irq),
    .mstatus_mie(mstatus_mie), .mie_msie(mie_msie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
    .ext_en(ext_en), .intr_ack(intr_ack), .intr_complete(intr_complete),
    .intr_req(intr_req), .intr_cause(intr_cause), .ext_id(ext_id), .mip(mip)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    logic [31:0] cause;
    int          id;
  } exp_t;
  exp_t expQ[$];

  // Reference model: sampled inputs, edge-pending memory, handshake phase (0 idle, 1 requesting, 2 in service).
  logic [NUM_EXT-1:0] mQ = '0, mQd = '0, mEdgePend = '0;
  logic mSip = 1'b0, mTip = 1'b0;
  int mPhase = 0;
  int mSvcLine = -1;
  logic [31:0] mCause = '0;
  int mId = 0;

  function automatic logic [NUM_EXT-1:0] effPend();
    logic [NUM_EXT-1:0] p;
    for (int i = 0; i < NUM_EXT; i++)
      p[i] = EDGE_MASK[i] ? (mEdgePend[i] | (mQ[i] & ~mQd[i])) : mQ[i];
    return p;
  endfunction

  function automatic logic [NUM_EXT-1:0] candidates();
    logic [NUM_EXT-1:0] c;
    c = effPend() & ext_en;
    if (mSvcLine >= 0) c[mSvcLine] = 1'b0;
    return c;
  endfunction

  function automatic int lowestLine(input logic [NUM_EXT-1:0] v);
    for (int i = 0; i < NUM_EXT; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  function automatic int chosenCode();
    if (mstatus_mie && mie_meie && candidates() != 0) return 11;
    if (mstatus_mie && mie_msie && mSip) return 3;
    if (mstatus_mie && mie_mtie && mTip) return 7;
    return 0;
  endfunction

  function automatic logic [NUM_EXT-1:0] nextEdgePend();
    logic [NUM_EXT-1:0] n;
    int clr;
    clr = (mPhase == 1 && intr_ack && mCause == CAUSE_MEI) ? mId : -1;
    for (int i = 0; i < NUM_EXT; i++)
      n[i] = EDGE_MASK[i] & ((mQ[i] & ~mQd[i]) | (mEdgePend[i] & (i != clr)));
    return n;
  endfunction

  function automatic logic [31:0] expMip();
    logic [31:0] m;
    m = '0;
    m[3] = mSip;
    m[7] = mTip;
    m[11] = |(effPend() & ext_en);
    return m;
  endfunction

  // Model steps on the same edges as the DUT; each new request pushes its expected cause/line.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mQ <= '0; mQd <= '0; mEdgePend <= '0; mSip <= 1'b0; mTip <= 1'b0;
      mPhase <= 0; mSvcLine <= -1; mCause <= '0; mId <= 0;
      expQ.delete();
    end else begin
      mEdgePend <= nextEdgePend();
      mQd <= mQ;
      mQ <= ext_irq;
      mSip <= msip;
      mTip <= mtip;
      if (mPhase == 0 && chosenCode() != 0) begin
        mPhase <= 1;
        mCause <= 32'h8000_0000 | 32'(chosenCode());
        mId <= (chosenCode() == 11) ? lowestLine(candidates()) : 0;
        expQ.push_back('{32'h8000_0000 | 32'(chosenCode()),
                         (chosenCode() == 11) ? lowestLine(candidates()) : 0});
      end else if (mPhase == 1 && intr_ack) begin
        mPhase <= 2;
        if (mCause == CAUSE_MEI) mSvcLine <= mId;
      end else if (mPhase == 2 && intr_complete && !intr_ack) begin
        mPhase <= 0;
        mSvcLine <= -1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: per-cycle req/mip check, and a scoreboard pop on every rising intr_req.
  logic prevReq = 1'b0;
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #1;
    checkOutput("intr_req", 32'(intr_req), 32'(mPhase == 1));
    checkOutput("mip", mip, expMip());
    if (intr_req && !prevReq) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL scoreboard: request with cause 0x%08h, expected no request", intr_cause);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb cause", intr_cause, e.cause);
        if (e.cause == CAUSE_MEI) checkOutput("sb ext_id", 32'(ext_id), 32'(e.id));
      end
    end
    prevReq = intr_req;
  end

  task automatic applyStimulus(input logic s, input logic t, input logic [NUM_EXT-1:0] e,
                               input logic [NUM_EXT-1:0] en, input logic gie, input logic [2:0] cls);
    @(negedge clk);
    msip = s; mtip = t; ext_irq = e; ext_en = en; mstatus_mie = gie;
    {mie_meie, mie_msie, mie_mtie} = cls;
  endtask

  task automatic applyRandom();
    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  8'($urandom), 1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)));
  endtask

  task automatic waitReq(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!intr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    assertCount++;
    if (!intr_req) begin
      failCount++;
      $display("[TB] FAIL %s: intr_req = 0 after 20 cycles, expected 1", tag);
    end
  endtask

  task automatic pulseAck();
    @(negedge clk) intr_ack = 1'b1;
    @(negedge clk) intr_ack = 1'b0;
  endtask

  task automatic pulseComplete();
    @(negedge clk) intr_complete = 1'b1;
    @(negedge clk) intr_complete = 1'b0;
  endtask

  task automatic drain();
    applyStimulus(1'b0, 1'b0, '0, '1, 1'b1, 3'b111);
    repeat (12) begin
      @(negedge clk);
      if (intr_req) begin
        pulseAck();
        pulseComplete();
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset held with every input high.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset intr_req", 32'(intr_req), 32'd0);
    checkOutput("reset mip", mip, 32'd0);
    checkOutput("reset cause", intr_cause, 32'd0);
    intr_ack = 1'b0;
    intr_complete = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset latency 1", 32'(intr_req), 32'd0);
    @(posedge clk); #1;
    checkOutput("post-reset latency 2", 32'(intr_req), 32'd1);
    checkOutput("post-reset cause", intr_cause, CAUSE_MEI);
    checkOutput("post-reset ext_id", 32'(ext_id), 32'd0);
    pulseAck();
    pulseComplete();
    drain();

    // Priority: software over timer, then timer alone.
    applyStimulus(1'b1, 1'b1, '0, '1, 1'b1, 3'b111);
    waitReq("prio msi");
    checkOutput("prio msi cause", intr_cause, 32'h8000_0003);
    pulseAck();
    applyStimulus(1'b0, 1'b1, '0, '1, 1'b1, 3'b111);
    pulseComplete();
    waitReq("prio mti");
    checkOutput("prio mti cause", intr_cause, 32'h8000_0007);
    drain();

    // External selection and in-service masking.
    applyStimulus(1'b0, 1'b0, 8'b0010_1000, '1, 1'b1, 3'b111);
    waitReq("ext select");
    checkOutput("ext select id", 32'(ext_id), 32'd3);
    pulseAck();
    repeat (3) begin
      @(negedge clk);
      checkOutput("no nesting", 32'(intr_req), 32'd0);
    end
    pulseComplete();
    waitReq("ext reselect");
    checkOutput("ext reselect id", 32'(ext_id), 32'd3);
    drain();

    // Edge line 2: single pulse, then a new rising edge that collides with the ack.
    applyStimulus(1'b0, 1'b0, 8'h04, '1, 1'b1, 3'b111);
    applyStimulus(1'b0, 1'b0, 8'h00, '1, 1'b1, 3'b111);
    waitReq("edge pulse");
    checkOutput("edge pulse id", 32'(ext_id), 32'd2);
    applyStimulus(1'b0, 1'b0, 8'h04, '1, 1'b1, 3'b111);
    pulseAck();
    applyStimulus(1'b0, 1'b0, 8'h00, '1, 1'b1, 3'b111);
    pulseComplete();
    waitReq("edge re-request");
    checkOutput("edge re-request id", 32'(ext_id), 32'd2);
    drain();

    // Frozen request while the source and global enable drop.
    applyStimulus(1'b1, 1'b0, '0, '1, 1'b1, 3'b111);
    waitReq("frozen");
    applyStimulus(1'b0, 1'b0, '0, '1, 1'b0, 3'b111);
    repeat (2) begin
      @(negedge clk);
      checkOutput("frozen req", 32'(intr_req), 32'd1);
      checkOutput("frozen cause", intr_cause, 32'h8000_0003);
    end
    pulseAck();
    checkOutput("frozen after ack", 32'(intr_req), 32'd0);
    pulseComplete();
    drain();

    // Async reset in SERVICE and in REQ.
    applyStimulus(1'b0, 1'b0, 8'h08, '1, 1'b1, 3'b111);
    waitReq("svc reset");
    pulseAck();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset req", 32'(intr_req), 32'd0);
    checkOutput("async reset cause", intr_cause, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("re-request latency 1", 32'(intr_req), 32'd0);
    @(posedge clk); #1;
    checkOutput("re-request latency 2", 32'(intr_req), 32'd1);
    checkOutput("re-request cause", intr_cause, CAUSE_MEI);
    checkOutput("re-request id", 32'(ext_id), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("reset in REQ", 32'(intr_req), 32'd0);
    @(negedge clk) rst = 1'b0;
    waitReq("after REQ reset");
    checkOutput("after REQ reset cause", intr_cause, CAUSE_MEI);
    drain();

    // Randomised traffic with handshakes and stray completes.
    for (int it = 0; it < 60; it++) begin
      applyRandom();
      repeat ($urandom_range(0, 3)) applyRandom();
      if (intr_req) begin
        repeat ($urandom_range(0, 2)) applyRandom();
        pulseAck();
        repeat ($urandom_range(0, 3)) applyRandom();
        pulseComplete();
      end else if ($urandom_range(0, 3) == 0) begin
        pulseComplete();
      end
    end
    drain();
    repeat (2) @(negedge clk);
    checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
